// File: rtl/spram_banked_port.sv
// Handshaked write/read front end arbitrating onto 1..4 single-ported 16K x 16 RAM banks.
// Each bank is modelled behaviourally with a registered read port and per-bank idle standby.
module spram_banked_port #(
    parameter int unsigned BANKS        = 4,
    parameter int unsigned AW           = 16,
    parameter int unsigned STARVE_LIMIT = 3,
    parameter int unsigned IDLE_STANDBY = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [AW-1:0]    wr_addr,
    input  logic [15:0]      wr_data,
    input  logic [3:0]       wr_mask,
    input  logic             rd_valid,
    output logic             rd_ready,
    input  logic [AW-1:0]    rd_addr,
    output logic [15:0]      rd_data,
    output logic             rd_data_valid,
    output logic [BANKS-1:0] bank_standby
);

    localparam int unsigned BW = (BANKS > 1) ? $clog2(BANKS) : 1;

    logic                   starve;
    logic                   want_w;
    logic                   want_r;
    logic                   wake;
    logic                   wr_acc;
    logic                   rd_acc;
    logic [3:0]             starve_cnt;
    logic [BW-1:0]          wbank;
    logic [BW-1:0]          rbank;
    logic [BW-1:0]          gbank;
    logic [BW-1:0]          rsel;
    logic                   rd_pend;
    logic [BANKS-1:0]       standby_q;
    logic [BANKS-1:0][15:0] dout;

    if (BANKS == 1) begin : g_one_bank
        assign wbank = '0;
        assign rbank = '0;
    end else begin : g_multi_bank
        assign wbank = wr_addr[AW-1:14];
        assign rbank = rd_addr[AW-1:14];
    end

    // Ready terms are written without their own channel's valid; when that valid is high
    // they reduce exactly to want_w / want_r gated by the target bank being awake.
    always_comb begin
        starve   = (starve_cnt == 4'(STARVE_LIMIT));
        want_w   = wr_valid && !(rd_valid && starve);
        want_r   = rd_valid && !want_w;
        gbank    = want_w ? wbank : rbank;
        wake     = reset_n && (want_w || want_r) && standby_q[gbank];
        wr_ready = reset_n && !(rd_valid && starve) && !standby_q[wbank];
        rd_ready = reset_n && (!wr_valid || starve) && !standby_q[rbank];
        wr_acc   = wr_valid && wr_ready;
        rd_acc   = rd_valid && rd_ready;
    end

    // Saturates at the limit so a wake cycle cannot push the count past the starve point.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            starve_cnt <= '0;
        end else if (!rd_valid || rd_acc) begin
            starve_cnt <= '0;
        end else if (!starve) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_pend <= 1'b0;
            rsel    <= '0;
        end else begin
            rd_pend <= rd_acc;
            if (rd_acc) begin
                rsel <= rbank;
            end
        end
    end

    assign rd_data_valid = reset_n && rd_pend;
    assign rd_data       = rd_data_valid ? dout[rsel] : '0;
    assign bank_standby  = standby_q;

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        logic        sel_w;
        logic        sel_r;
        logic        touch;
        logic        wren;
        logic        stby;
        logic [7:0]  idle_cnt;
        logic [13:0] addr;
        logic [15:0] q;
        logic [15:0] mem [16384];

        assign sel_w = wr_acc && (wbank == BW'(b));
        assign sel_r = rd_acc && (rbank == BW'(b));
        assign touch = sel_w || sel_r || (wake && (gbank == BW'(b)));
        assign addr  = sel_w ? wr_addr[13:0] : rd_addr[13:0];
        assign wren  = sel_w && (|wr_mask);

        always_ff @(posedge clk) begin
            if (reset_n && !stby) begin
                if (wren) begin
                    for (int unsigned n = 0; n < 4; n++) begin
                        if (wr_mask[n]) begin
                            mem[addr][4*n +: 4] <= wr_data[4*n +: 4];
                        end
                    end
                end else begin
                    q <= mem[addr];
                end
            end
        end

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                idle_cnt <= '0;
                stby     <= 1'b0;
            end else if (touch) begin
                idle_cnt <= '0;
                stby     <= 1'b0;
            end else if ((IDLE_STANDBY != 0) && (idle_cnt != 8'(IDLE_STANDBY))) begin
                idle_cnt <= idle_cnt + 8'd1;
                if (idle_cnt + 8'd1 == 8'(IDLE_STANDBY)) begin
                    stby <= 1'b1;
                end
            end
        end

        assign dout[b]      = q;
        assign standby_q[b] = stby;
    end

endmodule

// File: tb/tb_spram_banked_port.sv
// Directed self-checking bench for spram_banked_port (4 banks, starve limit 3, standby after 4 idle cycles).
module tb_spram_banked_port;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
    logic [3:0]  wr_mask;
    logic        rd_valid;
    logic        rd_ready;
    logic [15:0] rd_addr;
    logic [15:0] rd_data;
    logic        rd_data_valid;
    logic [3:0]  bank_standby;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    spram_banked_port #(
        .BANKS(4),
        .AW(16),
        .STARVE_LIMIT(3),
        .IDLE_STANDBY(4)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .wr_mask(wr_mask),
        .rd_valid(rd_valid),
        .rd_ready(rd_ready),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .rd_data_valid(rd_data_valid),
        .bank_standby(bank_standby)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [15:0] a, input logic [15:0] d, input logic [3:0] m);
        int unsigned n;
        n = 0;
        @(negedge clk);
        wr_addr  = a;
        wr_data  = d;
        wr_mask  = m;
        wr_valid = 1'b1;
        #1;
        while (!wr_ready && n < 8) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("wr_accept", {31'b0, wr_ready}, 32'd1);
        @(posedge clk);
        #1 wr_valid = 1'b0;
    endtask

    task automatic do_read(input logic [15:0] a, input logic [15:0] exp, input string tag,
                           output int unsigned waits);
        waits = 0;
        @(negedge clk);
        rd_addr  = a;
        rd_valid = 1'b1;
        #1;
        while (!rd_ready && waits < 8) begin
            @(negedge clk);
            #1;
            waits++;
        end
        chk({tag, "_accept"}, {31'b0, rd_ready}, 32'd1);
        @(posedge clk);
        #1 rd_valid = 1'b0;
        @(negedge clk);
        chk({tag, "_valid"}, {31'b0, rd_data_valid}, 32'd1);
        chk({tag, "_data"}, {16'b0, rd_data}, {16'b0, exp});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0]  addrs [4];
        logic [15:0]  datas [4];
        int unsigned  waits;
        int unsigned  n;

        addrs = '{16'h0001, 16'h4001, 16'h8001, 16'hC001};
        datas = '{16'h1001, 16'h2002, 16'h3003, 16'h4004};

        // Reset with both channels requesting: everything gated off.
        reset_n  = 1'b0;
        wr_valid = 1'b1;
        rd_valid = 1'b1;
        wr_addr  = '0;
        rd_addr  = '0;
        wr_data  = '0;
        wr_mask  = 4'hF;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wr_ready", {31'b0, wr_ready}, 32'd0);
        chk("rst_rd_ready", {31'b0, rd_ready}, 32'd0);
        chk("rst_rd_valid", {31'b0, rd_data_valid}, 32'd0);
        chk("rst_rd_data", {16'b0, rd_data}, 32'd0);
        chk("rst_standby", {28'b0, bank_standby}, 32'd0);
        wr_valid = 1'b0;
        rd_valid = 1'b0;
        reset_n  = 1'b1;

        // Simple write then immediate read, no wake needed.
        do_write(16'h0005, 16'h1234, 4'hF);
        do_read(16'h0005, 16'h1234, "t1_read", waits);
        chk("t1_no_wait", waits, 32'd0);

        // Nibble-masked overwrite in bank 1; bank 0 untouched.
        do_write(16'h0000, 16'h1111, 4'hF);
        do_write(16'h4000, 16'hAAAA, 4'hF);
        do_write(16'h4000, 16'h5555, 4'b0011);
        do_read(16'h4000, 16'hAA55, "t2_masked", waits);
        do_read(16'h0000, 16'h1111, "t2_bank0", waits);

        // Anti-starvation: 3 write grants, then one read grant, repeating.
        @(negedge clk);
        wr_addr  = 16'h0010;
        wr_data  = 16'hBEEF;
        wr_mask  = 4'hF;
        wr_valid = 1'b1;
        rd_addr  = 16'h0010;
        rd_valid = 1'b1;
        n = 0;
        #1;
        while (!rd_ready && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("t3_first_read", {31'b0, rd_ready}, 32'd1);
        @(negedge clk);
        chk("t3_valid0", {31'b0, rd_data_valid}, 32'd1);
        chk("t3_data0", {16'b0, rd_data}, 32'h0000BEEF);
        for (int rep = 0; rep < 2; rep++) begin
            for (int k = 0; k < 3; k++) begin
                #1;
                chk("t3_write_grant", {30'b0, wr_ready, rd_ready}, 32'b10);
                @(negedge clk);
            end
            #1;
            chk("t3_read_grant", {30'b0, wr_ready, rd_ready}, 32'b01);
            @(negedge clk);
            chk("t3_valid", {31'b0, rd_data_valid}, 32'd1);
            chk("t3_data", {16'b0, rd_data}, 32'h0000BEEF);
        end
        wr_valid = 1'b0;
        rd_valid = 1'b0;

        // Standby entry on bank 3 and a single wake cycle.
        do_write(16'hC000, 16'h3C3C, 4'hF);
        repeat (6) @(negedge clk);
        chk("t4_standby_all", {28'b0, bank_standby}, 32'hF);
        rd_addr  = 16'hC000;
        rd_valid = 1'b1;
        #1;
        chk("t4_wake_ready", {31'b0, rd_ready}, 32'd0);
        @(negedge clk);
        #1;
        chk("t4_retry_ready", {31'b0, rd_ready}, 32'd1);
        chk("t4_bank3_awake", {31'b0, bank_standby[3]}, 32'd0);
        @(posedge clk);
        #1 rd_valid = 1'b0;
        @(negedge clk);
        chk("t4_valid", {31'b0, rd_data_valid}, 32'd1);
        chk("t4_data", {16'b0, rd_data}, 32'h00003C3C);

        for (int i = 0; i < 4; i++) begin
            do_write(addrs[i], datas[i], 4'hF);
        end

        // Read accepted, then reset in the following cycle: its pulse is suppressed.
        @(negedge clk);
        rd_addr  = 16'h0005;
        rd_valid = 1'b1;
        n = 0;
        #1;
        while (!rd_ready && n < 8) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("t6_accept", {31'b0, rd_ready}, 32'd1);
        @(posedge clk);
        #1;
        reset_n  = 1'b0;
        rd_valid = 1'b0;
        @(negedge clk);
        chk("t6_valid_rst", {31'b0, rd_data_valid}, 32'd0);
        chk("t6_data_rst", {16'b0, rd_data}, 32'd0);
        repeat (2) @(negedge clk);
        chk("t6_valid_rst2", {31'b0, rd_data_valid}, 32'd0);
        chk("t6_standby_rst", {28'b0, bank_standby}, 32'd0);

        // Right after release every bank is awake: four back-to-back reads across banks.
        reset_n  = 1'b1;
        rd_addr  = addrs[0];
        rd_valid = 1'b1;
        #1;
        chk("t5_ready0", {31'b0, rd_ready}, 32'd1);
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("t5_valid", {31'b0, rd_data_valid}, 32'd1);
            chk("t5_data", {16'b0, rd_data}, {16'b0, datas[i-1]});
            if (i < 4) begin
                rd_addr = addrs[i];
                #1;
                chk("t5_ready", {31'b0, rd_ready}, 32'd1);
            end else begin
                rd_valid = 1'b0;
            end
        end
        @(negedge clk);
        chk("t5_no_extra", {31'b0, rd_data_valid}, 32'd0);

        do_read(16'h0005, 16'h1234, "t6_retained", waits);
        do_read(16'h4000, 16'hAA55, "t6_retained_b1", waits);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
